// File: rtl/logistic_pkg.sv
// logistic_pkg
//   Shared definitions for the Q8.8 logistic-map sequencer:
//   Q8.8 constants, the controller state encoding and a saturating helper.
package logistic_pkg;

    localparam logic [15:0] ONE_Q88 = 16'h0100;  // 1.0 in Q8.8
    localparam logic [15:0] R_MAX   = 16'h0400;  // 4.0 in Q8.8, top of the useful r range

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN,
        ST_HOLD
    } state_t;

    // Clamp a Q8.8 value to 1.0.
    function automatic logic [15:0] sat_q88(input logic [15:0] v);
        return (v > ONE_Q88) ? ONE_Q88 : v;
    endfunction

endpackage

// File: rtl/logistic_iter_dp.sv
// logistic_iter_dp
//   One logistic-map iteration y = r*x*(1-x) as a registered 2-stage pipeline.
//   A go pulse yields done (with y) exactly two cycles later; no control logic.
// Ports
//   clk    in   1   clock
//   reset  in   1   synchronous active-high reset
//   go     in   1   start an iteration on x, r
//   x      in   16  Q8.8 current iterate (0..1.0)
//   r      in   16  Q8.8 growth rate
//   done   out  1   y is valid this cycle
//   y      out  16  Q8.8 next iterate, saturated to 1.0
module logistic_iter_dp
    import logistic_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] x,
    input  logic [15:0] r,
    output logic        done,
    output logic [15:0] y
);

    logic [15:0] diff;
    logic [15:0] t_next;
    logic [15:0] y_next;
    logic [15:0] t_q;
    logic        v1_q;
    logic [15:0] y_q;
    logic        done_q;

    // x*(1-x) as Q0.16; peaks at 0x4000 for x = 0.5 so 16 bits suffice.
    assign diff   = ONE_Q88 - x;
    assign t_next = x * diff;
    // (r*t) >> 16 lands the Q8.8 * Q0.16 product back in Q8.8.
    assign y_next = sat_q88(16'((32'(r) * 32'(t_q)) >> 16));

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q    <= '0;
            v1_q   <= 1'b0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            t_q    <= t_next;
            v1_q   <= go;
            y_q    <= y_next;
            done_q <= v1_q;
        end
    end

    assign done = done_q;
    assign y    = y_q;

endmodule

// File: rtl/logistic_seq_ctrl.sv
// logistic_seq_ctrl
//   Sequencer for the Q8.8 logistic-map chaos source. Takes a seed/r/warm-up
//   configuration, runs the iteration datapath, discards warm-up iterates,
//   streams later iterates and reseeds automatically when the orbit collapses.
// Ports
//   clk         in   1       clock
//   reset       in   1       synchronous active-high reset
//   cfg_valid   in   1       config offer
//   cfg_ready   out  1       high only in IDLE
//   cfg_seed    in   16      Q8.8 initial x (clamped to 1.0)
//   cfg_r       in   16      Q8.8 growth rate
//   cfg_warmup  in   W_WARM  iterations discarded before streaming
//   stop        in   1       abort to IDLE
//   out_valid   out  1       iterate available
//   out_ready   in   1       consumer accepts
//   out_data    out  16      Q8.8 iterate
//   busy        out  1       not IDLE
//   reseed_cnt  out  8       collapse reseeds since last config, saturating
module logistic_seq_ctrl
    import logistic_pkg::*;
#(
    parameter int unsigned W_WARM      = 8,
    parameter logic [15:0] RESEED_STEP = 16'h0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [15:0]       cfg_seed,
    input  logic [15:0]       cfg_r,
    input  logic [W_WARM-1:0] cfg_warmup,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic [7:0]        reseed_cnt
);

    state_t            state_q, state_d;
    logic [15:0]       seed_q, seed_d;
    logic [15:0]       r_q, r_d;
    logic [15:0]       x_q, x_d;
    logic [W_WARM-1:0] warm_q, warm_d;
    logic              pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic [7:0]        reseed_q, reseed_d;

    logic              go;
    logic              done;
    logic [15:0]       y;
    logic              collapse;
    logic [15:0]       next_seed;

    // Reseed value kept strictly inside 0x0001..0x00FF.
    function automatic logic [15:0] reseed_value(input logic [15:0] s);
        logic [15:0] v;
        v = s + RESEED_STEP;
        if (v > 16'h00FF) v = {8'h00, v[7:0]};
        if (v == 16'h0000) v = 16'h0001;
        return v;
    endfunction

    logistic_iter_dp u_dp (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .x     (x_q),
        .r     (r_q),
        .done  (done),
        .y     (y)
    );

    assign collapse  = (y == 16'h0000) || (y == x_q);
    assign next_seed = reseed_value(seed_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            r_q         <= '0;
            x_q         <= '0;
            warm_q      <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            reseed_q    <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            r_q         <= r_d;
            x_q         <= x_d;
            warm_q      <= warm_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            reseed_q    <= reseed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        r_d         = r_q;
        x_d         = x_q;
        warm_d      = warm_q;
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        reseed_d    = reseed_q;
        go          = 1'b0;

        if (stop) begin
            // pending is dropped so a done still in the pipe is ignored later.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            pending_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_d       = cfg_r;
                        seed_d    = sat_q88(cfg_seed);
                        x_d       = sat_q88(cfg_seed);
                        warm_d    = cfg_warmup;
                        reseed_d  = '0;
                        pending_d = 1'b0;
                        state_d   = (cfg_warmup != '0) ? ST_WARM : ST_RUN;
                    end
                end
                ST_WARM, ST_RUN: begin
                    if (pending_q && done) begin
                        pending_d = 1'b0;
                        if (collapse) begin
                            seed_d   = next_seed;
                            x_d      = next_seed;
                            reseed_d = (reseed_q == 8'hFF) ? 8'hFF : reseed_q + 8'd1;
                        end else if (state_q == ST_WARM) begin
                            x_d    = y;
                            warm_d = warm_q - 1'b1;
                            if (warm_q == W_WARM'(1)) state_d = ST_RUN;
                        end else begin
                            x_d         = y;
                            out_data_d  = y;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end else if (!pending_q) begin
                        go        = 1'b1;
                        pending_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // go is raised in the accept cycle so the datapath captures
                    // it on the accept edge; this gives 3 cycles per sample.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_RUN;
                        go          = 1'b1;
                        pending_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign reseed_cnt = reseed_q;

endmodule

// File: tb/tb_logistic_seq_ctrl.sv
// tb_logistic_seq_ctrl
//   Directed bench for logistic_seq_ctrl with hand-computed Q8.8 iterates.
module tb_logistic_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_seed;
    logic [15:0] cfg_r;
    logic [7:0]  cfg_warmup;
    logic        stop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  reseed_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logistic_seq_ctrl #(
        .W_WARM      (8),
        .RESEED_STEP (16'h0013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_seed   (cfg_seed),
        .cfg_r      (cfg_r),
        .cfg_warmup (cfg_warmup),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .reseed_cnt (reseed_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [15:0] seed, input logic [15:0] r, input logic [7:0] warm);
        cfg_seed   = seed;
        cfg_r      = r;
        cfg_warmup = warm;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    // Waits (bounded) for out_valid, then checks the latency and the sample.
    task automatic expect_sample(input string tag, input int lat, input logic [15:0] data);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_seed   = '0;
        cfg_r      = '0;
        cfg_warmup = '0;
        stop       = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_data",   32'(out_data),   32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_ready",  32'(cfg_ready),  32'd1);
        check("rst_reseed", 32'(reseed_cnt), 32'd0);

        // Plain streaming: 0x80 -> 0xE0 -> 0x62 -> 0xD3, 3 cycles apart.
        out_ready = 1'b1;
        configure(16'h0080, 16'h0380, 8'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_cfg_ready", 32'(cfg_ready), 32'd0);
        expect_sample("t2_s0", 3, 16'h00E0);
        tick();
        expect_sample("t2_s1", 2, 16'h0062);
        tick();
        expect_sample("t2_s2", 2, 16'h00D3);
        do_stop();
        check("t2_stop_busy",  32'(busy),      32'd0);
        check("t2_stop_valid", 32'(out_valid), 32'd0);

        // One warm-up iteration swallows 0xE0.
        configure(16'h0080, 16'h0380, 8'd1);
        expect_sample("t3_s0", 6, 16'h0062);
        check("t3_reseed", 32'(reseed_cnt), 32'd0);
        do_stop();

        // r = 4.0: 0x100 emitted, next y = 0 collapses, restart from 0x93 -> 0xFA.
        configure(16'h0080, 16'h0400, 8'd0);
        expect_sample("t4_s0", 3, 16'h0100);
        check("t4_reseed0", 32'(reseed_cnt), 32'd0);
        tick();
        expect_sample("t4_s1", 5, 16'h00FA);
        check("t4_reseed1", 32'(reseed_cnt), 32'd1);
        do_stop();

        // Backpressure: held sample stays put; cfg offers are ignored.
        out_ready = 1'b0;
        configure(16'h0080, 16'h0380, 8'd0);
        expect_sample("t5_s0", 3, 16'h00E0);
        cfg_seed  = 16'h0040;
        cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_data",  32'(out_data),  32'h00E0);
            check("t5_hold_cfgrdy", 32'(cfg_ready), 32'd0);
        end
        cfg_valid = 1'b0;
        do_stop();
        check("t5_stop_valid", 32'(out_valid), 32'd0);
        check("t5_stop_busy",  32'(busy),      32'd0);
        check("t5_stop_ready", 32'(cfg_ready), 32'd1);

        // Seed 0x200 clamps to 0x100, y = 0 collapses, reseed 0x0113 -> 0x13 -> 0x3D.
        configure(16'h0200, 16'h0380, 8'd0);
        expect_sample("t6_s0", 6, 16'h003D);
        check("t6_reseed", 32'(reseed_cnt), 32'd1);

        // Reset while holding a sample.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_valid",  32'(out_valid),  32'd0);
        check("t1_busy",   32'(busy),       32'd0);
        check("t1_ready",  32'(cfg_ready),  32'd1);
        check("t1_reseed", 32'(reseed_cnt), 32'd0);
        check("t1_data",   32'(out_data),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
